br_rr_dispatch: RTL
===================

// Module: br_rr_dispatch
//
// PURPOSE
// - Round-robin fan-out: one upstream valid/ready stream feeds NumConsumers downstream valid/ready
//   streams. Each accepted beat goes to the next eligible consumer after the last one served.
// - The counterpart to round-robin arbitration, which is many-to-one; this block is one-to-many.
// - Used to spread work across replicated engines. Each output has a 1-entry register, so latency is 1 cycle.
//
// PARAMETERS
// - NumConsumers  2  number of downstream ports; must be >= 2 (static assert)
// - Width         8  payload width in bits; must be >= 1 (static assert)
//
// PORTS
// - clk            in   1               clock
// - rst_n          in   1               reset, asynchronous, active-low
// - push_valid     in   1               upstream beat valid
// - push_ready     out  1               upstream beat accepted when push_valid && push_ready
// - push_data      in   Width           upstream payload
// - pop_valid      out  NumConsumers    per-consumer valid, driven from the slot register
// - pop_ready      in   NumConsumers    per-consumer ready
// - pop_data       out  NumConsumers x Width  per-consumer payload, from the slot register
// - last_dispatch  out  NumConsumers    one-hot index of the consumer most recently served
//
// BEHAVIOUR
// - Reset (async assert, sync deassert):
//   - slot_valid = 0, so pop_valid = 0.
//   - last_dispatch = 1 << (NumConsumers-1), so the first beat goes to consumer 0.
//   - Slot data is not reset. pop_data[i] is don't-care while pop_valid[i] = 0.
// - avail[i] = !slot_valid[i] || pop_ready[i]. A slot can be refilled in the same cycle it drains.
// - Selection: consider avail bits at indices strictly above the last_dispatch index.
//   - Pick the lowest such index.
//   - If there is none, wrap around and pick the lowest avail index overall.
//   - The result sel is one-hot.
// - push_ready = |avail. This is combinational from pop_ready; no path exists from push_valid to push_ready.
// - On push_valid && push_ready:
//   - slot_data[sel] <= push_data; slot_valid[sel] <= 1.
//   - last_dispatch <= sel.
// - On pop_valid[i] && pop_ready[i] with no refill of slot i: slot_valid[i] <= 0.
// - Throughput is 1 beat/cycle whenever any consumer is available. Latency is push to pop_valid = 1 cycle.
// - All consumers full and not ready: push_ready = 0 and state holds.
// - last_dispatch changes only on an accepted push.
// - Reset mid-operation: all slots are discarded and the pointer returns to its reset value.
// - Assertions:
//   - push_valid && !push_ready |=> push_valid && $stable(push_data).
//   - pop_valid[i] && !pop_ready[i] |=> pop_valid[i] && $stable(pop_data[i]).
//   - last_dispatch is always $onehot.
//
// CONFIGURATION
// - Macro BR_RR_DISPATCH_STRICT_EN.
// - Defined (strict round-robin):
//   - sel is always the consumer after last_dispatch, with wrap-around.
//   - push_ready = avail[that consumer]. A busy consumer stalls upstream; it is never skipped.
//   - Gives a deterministic destination sequence 0,1,..,N-1,0,...
// - Undefined (default): work-conserving selection as described in BEHAVIOUR.
//
// STRUCTURE
// - No shared package is needed; the only constant is local: IdxWidth = $clog2(NumConsumers).
// - Sub-module br_rr_dispatch_select: combinational rotating-priority picker.
//   - Inputs avail and last_dispatch; output one-hot sel.
//   - Builds an above-pointer mask from last_dispatch, then applies a two-pass priority encode.
// - Top level holds the slot registers, the last_dispatch register, handshake logic and the STRICT ifdef.
//
// TESTING (NumConsumers=3, Width=8)
// - Reset, then push 0xA0,0xA1,0xA2,0xA3 with pop_ready=3'b111
//   -> consumers 0,1,2,0 receive them; each pop_valid rises 1 cycle after acceptance;
//      last_dispatch = 001,010,100,001.
// - pop_ready=3'b000; push 4 beats
//   -> 3 accepted into slots 0,1,2; push_ready=0 on the 4th beat; pop_valid=3'b111;
//      pop_data stays stable.
// - Slots full, pop_ready=3'b010, push 0xB0 -> same-cycle drain and refill of slot 1;
//   pop_data[1]=0xB0 next cycle.
// - Default build: last_dispatch=001, slot 1 full and stalled, push 0xC0
//   -> consumer 2 is skipped to; last_dispatch=100.
//   - Same stimulus with BR_RR_DISPATCH_STRICT_EN defined -> push_ready=0 until consumer 1 is available.
// - Assert rst_n low for 1 cycle while slots are full
//   -> pop_valid=0 immediately; the next push goes to consumer 0.
// - Random push and pop_ready, 10k cycles, scoreboard
//   -> no loss or duplication; per-consumer order is preserved; all assertions hold.

Source files
------------

// File: rtl/br_rr_dispatch_select.sv
// ---------------------------------------------------------------------------
// br_rr_dispatch_select
// Combinational rotating-priority picker for the round-robin dispatcher.
//
// Ports:
//   avail          in   NumConsumers  consumers able to take a beat this cycle
//   last_dispatch  in   NumConsumers  one-hot index of the consumer served last
//   sel            out  NumConsumers  one-hot choice (all zero if nothing avail)
//
// Picks the lowest available index strictly above last_dispatch. If there is
// none, it wraps around and picks the lowest available index overall.
// ---------------------------------------------------------------------------
module br_rr_dispatch_select #(
  parameter int NumConsumers = 2
) (
  input  logic [NumConsumers-1:0] avail,
  input  logic [NumConsumers-1:0] last_dispatch,
  output logic [NumConsumers-1:0] sel
);

  logic [NumConsumers-1:0] w_upto_mask;
  logic [NumConsumers-1:0] w_above_mask;
  logic [NumConsumers-1:0] w_masked;
  logic [NumConsumers-1:0] w_pick_above;
  logic [NumConsumers-1:0] w_pick_all;

  // (onehot << 1) - 1 sets every bit at or below the pointer. When the pointer
  // is the top bit the shift overflows to zero, and the subtraction produces
  // all ones. The inverted mask is then empty, which forces the wrap pass.
  assign w_upto_mask  = (last_dispatch << 1) - {{(NumConsumers-1){1'b0}}, 1'b1};
  assign w_above_mask = ~w_upto_mask;
  assign w_masked     = avail & w_above_mask;

  // x & -x isolates the lowest set bit.
  assign w_pick_above = w_masked & (~w_masked + {{(NumConsumers-1){1'b0}}, 1'b1});
  assign w_pick_all   = avail & (~avail + {{(NumConsumers-1){1'b0}}, 1'b1});

  assign sel = (|w_masked) ? w_pick_above : w_pick_all;

endmodule

// File: rtl/br_rr_dispatch.sv
// ---------------------------------------------------------------------------
// br_rr_dispatch
// Round-robin fan-out. One upstream valid/ready stream feeds NumConsumers
// downstream valid/ready streams. Each output has a 1-entry slot register, so
// the latency from push to pop_valid is one cycle.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   push_valid/ready/data          upstream stream
//   pop_valid/ready/data [N]       per-consumer streams, driven from slots
//   last_dispatch  [N]             one-hot index of the consumer served last
//
// Configuration macro BR_RR_DISPATCH_STRICT_EN:
//   defined   - strict rotation 0,1,..,N-1,0. A busy consumer stalls upstream.
//   undefined - work-conserving. A busy consumer is skipped.
// ---------------------------------------------------------------------------
module br_rr_dispatch #(
  parameter int NumConsumers = 2,
  parameter int Width        = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push_valid,
  output logic                                push_ready,
  input  logic [Width-1:0]                    push_data,
  output logic [NumConsumers-1:0]             pop_valid,
  input  logic [NumConsumers-1:0]             pop_ready,
  output logic [NumConsumers-1:0][Width-1:0]  pop_data,
  output logic [NumConsumers-1:0]             last_dispatch
);

  if (NumConsumers < 2) begin : g_bad_num_consumers
    $error("br_rr_dispatch: NumConsumers must be >= 2");
  end
  if (Width < 1) begin : g_bad_width
    $error("br_rr_dispatch: Width must be >= 1");
  end

  logic [NumConsumers-1:0]            r_slot_valid;
  logic [NumConsumers-1:0][Width-1:0] r_slot_data;
  logic [NumConsumers-1:0]            r_last;

  logic [NumConsumers-1:0] w_avail;
  logic [NumConsumers-1:0] w_sel;
  logic [NumConsumers-1:0] w_fill;
  logic                    w_accept;

  // A slot can be refilled in the same cycle it drains.
  assign w_avail = ~r_slot_valid | pop_ready;

`ifdef BR_RR_DISPATCH_STRICT_EN
  logic [NumConsumers-1:0] w_next;
  // The destination is always the consumer after the pointer. It is only
  // usable when that consumer can take the beat.
  assign w_next = {r_last[NumConsumers-2:0], r_last[NumConsumers-1]};
  assign w_sel  = w_next & w_avail;
`else
  br_rr_dispatch_select #(
    .NumConsumers (NumConsumers)
  ) u_select (
    .avail         (w_avail),
    .last_dispatch (r_last),
    .sel           (w_sel)
  );
`endif

  // Depends only on slot state and pop_ready, never on push_valid.
  assign push_ready = |w_sel;
  assign w_accept   = push_valid & push_ready;
  assign w_fill     = w_sel & {NumConsumers{w_accept}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_valid <= '0;
      r_last       <= {1'b1, {(NumConsumers-1){1'b0}}};
    end else begin
      for (int i = 0; i < NumConsumers; i++) begin
        if (w_fill[i]) begin
          r_slot_valid[i] <= 1'b1;
        end else if (pop_ready[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
      if (w_accept) begin
        r_last <= w_sel;
      end
    end
  end

  // Payload storage has no reset; the data is qualified by r_slot_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumConsumers; i++) begin
      if (w_fill[i]) begin
        r_slot_data[i] <= push_data;
      end
    end
  end

  assign pop_valid     = r_slot_valid;
  assign pop_data      = r_slot_data;
  assign last_dispatch = r_last;

`ifndef SYNTHESIS
  ap_push_hold : assert property (@(posedge clk) disable iff (!rst_n)
    push_valid && !push_ready |=> push_valid && $stable(push_data));

  ap_last_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot(r_last));

  for (genvar gi = 0; gi < NumConsumers; gi++) begin : g_pop_hold
    ap_pop_hold : assert property (@(posedge clk) disable iff (!rst_n)
      pop_valid[gi] && !pop_ready[gi] |=> pop_valid[gi] && $stable(pop_data[gi]));
  end
`endif

endmodule
